// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//   Pipeline front end. Generates the fetch PC and issues requests to
//   instruction memory over a req/gnt/rvalid handshake. Returned words are
//   buffered in a small in-order queue, and one registered instruction per
//   cycle is presented to decode.
//
// Parameters
//   RESET_PC   first fetch PC after reset
//   NOP_INSTR  word driven on instr_reg_fetch while no valid instruction is held
//   QDEPTH     queue entries and maximum outstanding requests (2 or 4)
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   imem_req / imem_addr     request valid / word-aligned request address
//   imem_gnt                 request accepted this cycle
//   imem_rvalid / imem_rdata in-order response valid / instruction word
//   redirect_valid / _pc     taken branch/jump: flush and refetch from _pc
//   stall_decode             decode cannot accept a new instruction
//   instr_valid_fetch        instr_reg_fetch / pc_fetch hold a valid instruction
//   instr_reg_fetch          instruction to decode
//   pc_fetch                 PC of instr_reg_fetch
//   fetch_misalign           (FETCH_MISALIGN_TRAP_EN only) last redirect target
//                            was not word aligned
//
// Build option
//   FETCH_MISALIGN_TRAP_EN   adds the fetch_misalign output
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_decode,
    output logic        instr_valid_fetch,
    output logic [31:0] instr_reg_fetch,
    output logic [31:0] pc_fetch
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int unsigned PW = (QDEPTH > 2) ? 2 : 1;  // queue pointer width
    localparam int unsigned CW = PW + 1;                // counts 0..QDEPTH
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   pc_req;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;        // slots tagged with a PC (filled or awaiting data)
    logic [CW-1:0] outstanding;  // tagged slots still awaiting their response
    logic [CW-1:0] discard;      // stale responses still to be dropped

    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          fire;
    logic          fill;
    logic          drop;
    logic          resp_live;
    logic          pop;
    logic          head_ready;
    logic [CW-1:0] filled_cnt;
    logic [PW-1:0] fill_idx;
    logic [31:0]   head_instr;
    logic [CW-1:0] discard_redir;
    logic [CW-1:0] discard_dec;
    logic [31:0]   redirect_aligned;

    always_comb begin
        imem_req  = (state == FETCH) && !redirect_valid && (count < QD);
        imem_addr = pc_req;
        fire      = imem_req && imem_gnt;

        // A response is owed either to the discard counter or to the oldest
        // outstanding slot; with neither pending it is ignored.
        resp_live = imem_rvalid && ((discard != '0) || (outstanding != '0));
        drop      = imem_rvalid && (discard != '0);
        fill      = imem_rvalid && (discard == '0) && (outstanding != '0) && !redirect_valid;

        filled_cnt = count - outstanding;
        fill_idx   = head + PW'(filled_cnt);

        // When nothing is filled yet, the oldest outstanding slot is the head,
        // so a response arriving now is forwarded straight into the output
        // register. This gives grant->valid in two cycles and lets a
        // QDEPTH=2 queue sustain one instruction per cycle.
        head_ready = (filled_cnt != '0) || fill;
        head_instr = (filled_cnt != '0) ? q_instr[head] : imem_rdata;
        pop        = !redirect_valid && head_ready && (!instr_valid_fetch || !stall_decode);

        discard_redir    = discard + outstanding - CW'(resp_live);
        discard_dec      = discard - CW'(drop);
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    end

    // Queue storage needs no reset: validity is carried by the counters.
    always_ff @(posedge clk) begin
        if (fire) begin
            q_pc[tail] <= pc_req;
        end
        if (fill) begin
            q_instr[fill_idx] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= BOOT;
            pc_req            <= RESET_PC;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            outstanding       <= '0;
            discard           <= '0;
            instr_valid_fetch <= 1'b0;
            instr_reg_fetch   <= NOP_INSTR;
            pc_fetch          <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Every in-flight request becomes a stale response to drop; a
            // response arriving this very cycle is already counted off.
            pc_req            <= redirect_aligned;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            outstanding       <= '0;
            discard           <= discard_redir;
            state             <= (discard_redir != '0) ? DRAIN : FETCH;
            instr_valid_fetch <= 1'b0;
            instr_reg_fetch   <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign    <= (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (fire) begin
                pc_req <= pc_req + 32'd4;
                tail   <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count       <= count + CW'(fire) - CW'(pop);
            outstanding <= outstanding + CW'(fire) - CW'(fill);
            discard     <= discard_dec;

            case (state)
                BOOT:    state <= FETCH;
                FETCH:   state <= FETCH;
                DRAIN:   if (discard_dec == '0) state <= FETCH;
                default: state <= BOOT;
            endcase

            if (pop) begin
                instr_valid_fetch <= 1'b1;
                instr_reg_fetch   <= head_instr;
                pc_fetch          <= q_pc[head];
            end else if (!stall_decode) begin
                instr_valid_fetch <= 1'b0;
                instr_reg_fetch   <= NOP_INSTR;
            end
        end
    end

endmodule
